// File: rtl/window_shift_buffer_pkg.sv
// Shared types, helpers and flattened-bus slice macro for the conv input datapath.
// Lane/register n of a flattened bus lives at [`WSB_SLICE(n, width)].
`ifndef WSB_SLICE
`define WSB_SLICE(n, w) ((n)+1)*(w)-1:(n)*(w)
`endif

package window_shift_buffer_pkg;

  localparam int WSB_WIDTH = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/window_need_ctrl.sv
// Window bookkeeping: need counter, window-valid, fill level and sticky alignment error.
// All outputs registered (one-edge latency); clear has priority over accept and consume.
module window_need_ctrl
  import window_shift_buffer_pkg::*;
#(
  parameter int N_REG  = 31,
  parameter int LANES  = 2,
  parameter int STRIDE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         accept,
  input  logic                         lane_ovf,
  input  logic                         consume,
  input  logic [clog2(LANES+1)-1:0]    m,
  output logic                         win_valid,
  output logic [clog2(N_REG+1)-1:0]    fill,
  output logic                         align_err
);

  localparam int FW = clog2(N_REG + 1);
  localparam int NW = FW + 1;

  logic signed [NW-1:0] need_q, need_d;
  logic signed [NW-1:0] base, m_s, rem;
  logic [FW-1:0]        fill_q, fill_d;
  logic [FW:0]          fill_sum;
  logic                 win_valid_q, win_valid_d;
  logic                 align_err_q, align_err_d;

  always_comb begin
    need_d      = need_q;
    win_valid_d = win_valid_q;
    fill_d      = fill_q;
    align_err_d = align_err_q;
    m_s         = NW'(m);
    base        = consume ? NW'(STRIDE) : need_q;
    rem         = base - m_s;
    fill_sum    = (FW+1)'(fill_q) + (FW+1)'(m);

    if (clear) begin
      need_d      = NW'(N_REG);
      win_valid_d = 1'b0;
      fill_d      = '0;
      align_err_d = 1'b0;
    end else begin
      if (consume) begin
        win_valid_d = 1'b0;
        need_d      = NW'(STRIDE);
      end
      if (accept && lane_ovf) align_err_d = 1'b1;
      if (accept && (m != '0)) begin
        fill_d = (fill_sum > (FW+1)'(N_REG)) ? FW'(N_REG) : fill_sum[FW-1:0];
        // A negative remainder means the window swallowed samples past the stride point.
        if (rem[NW-1] || (rem == '0)) begin
          need_d      = '0;
          win_valid_d = 1'b1;
          if (rem[NW-1]) align_err_d = 1'b1;
        end else begin
          need_d = rem;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_q      <= NW'(N_REG);
      win_valid_q <= 1'b0;
      fill_q      <= '0;
      align_err_q <= 1'b0;
    end else begin
      need_q      <= need_d;
      win_valid_q <= win_valid_d;
      fill_q      <= fill_d;
      align_err_q <= align_err_d;
    end
  end

  assign win_valid = win_valid_q;
  assign fill      = fill_q;
  assign align_err = align_err_q;

endmodule

// File: rtl/window_shift_buffer.sv
// Sliding-window input buffer: shifts 1..LANES samples per beat into an N_REG-deep window.
// One-edge latency; input is back-pressured while a window is pending and not being taken.
module window_shift_buffer
  import window_shift_buffer_pkg::*;
#(
  parameter int WIDTH  = WSB_WIDTH,
  parameter int N_REG  = 31,
  parameter int LANES  = 2,
  parameter int STRIDE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [clog2(LANES+1)-1:0]   in_num,
  input  logic [WIDTH*LANES-1:0]      in_data,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [WIDTH*N_REG-1:0]      all_outputs,
  output logic [clog2(N_REG+1)-1:0]   fill,
  output logic                        align_err
);

  localparam int MW = clog2(LANES + 1);
  localparam int SW = clog2(N_REG + LANES);

  if (N_REG < LANES) begin : g_bad_lanes
    $error("window_shift_buffer: N_REG must be >= LANES");
  end
  if (STRIDE < 1 || STRIDE > N_REG) begin : g_bad_stride
    $error("window_shift_buffer: STRIDE must be in 1..N_REG");
  end

  logic [WIDTH-1:0] win_q [N_REG];
  logic [WIDTH-1:0] win_d [N_REG];
  logic [WIDTH-1:0] ext   [N_REG+LANES];
  logic [MW-1:0]    m;
  logic             lane_ovf, accept, consume;

  assign lane_ovf = in_num > MW'(LANES);
  assign m        = lane_ovf ? MW'(LANES) : in_num;
  assign in_ready = !clear && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = win_valid && win_ready;

  window_need_ctrl #(
    .N_REG  (N_REG),
    .LANES  (LANES),
    .STRIDE (STRIDE)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept),
    .lane_ovf  (lane_ovf),
    .consume   (consume),
    .m         (m),
    .win_valid (win_valid),
    .fill      (fill),
    .align_err (align_err)
  );

  // Window followed by incoming lanes: a shift by m is just a read at offset m.
  for (genvar n = 0; n < N_REG; n++) begin : g_ext_win
    assign ext[n] = win_q[n];
    assign all_outputs[`WSB_SLICE(n, WIDTH)] = win_q[n];
  end
  for (genvar k = 0; k < LANES; k++) begin : g_ext_lane
    assign ext[N_REG+k] = in_data[`WSB_SLICE(k, WIDTH)];
  end

  always_comb begin
    for (int i = 0; i < N_REG; i++) begin
      win_d[i] = win_q[i];
      if (clear) begin
        win_d[i] = '0;
      end else if (accept && (m != '0)) begin
        win_d[i] = ext[SW'(i) + SW'(m)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) win_q[i] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: tb/tb_window_shift_buffer.sv
// Self-checking bench for window_shift_buffer: table-driven beats with a scoreboard queue
// plus hand-written stall, clear, reset and stride-1 sequences.
module tb_window_shift_buffer;

  localparam int W = 32;
  localparam int N = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build: LANES=2, STRIDE=2
  logic           clear0 = 1'b0, in_valid0 = 1'b0, win_ready0 = 1'b0;
  logic [1:0]     in_num0 = '0;
  logic [2*W-1:0] in_data0 = '0;
  logic           in_ready0, win_valid0, err0;
  logic [N*W-1:0] all0;
  logic [4:0]     fill0;

  // Stride-1 build: LANES=1, STRIDE=1
  logic           clear1 = 1'b0, in_valid1 = 1'b0, win_ready1 = 1'b0;
  logic [0:0]     in_num1 = '0;
  logic [W-1:0]   in_data1 = '0;
  logic           in_ready1, win_valid1, err1;
  logic [N*W-1:0] all1;
  logic [4:0]     fill1;

  window_shift_buffer #(.WIDTH(W), .N_REG(N), .LANES(2), .STRIDE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_num(in_num0), .in_data(in_data0), .win_valid(win_valid0), .win_ready(win_ready0),
    .all_outputs(all0), .fill(fill0), .align_err(err0)
  );

  window_shift_buffer #(.WIDTH(W), .N_REG(N), .LANES(1), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_num(in_num1), .in_data(in_data1), .win_valid(win_valid1), .win_ready(win_ready1),
    .all_outputs(all1), .fill(fill1), .align_err(err1)
  );

  typedef struct {
    int          num;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        wv;
    int          fill;
    logic        err;
    logic [31:0] r0;
    logic [31:0] r30;
  } vec_t;

  vec_t tbl [16];
  vec_t sb0 [$];
  vec_t sb1 [$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input vec_t e, input logic wv, input logic [4:0] fl,
                     input logic er, input logic [31:0] a0, input logic [31:0] a30);
    chk({tag, " win_valid"}, 32'(wv), 32'(e.wv));
    chk({tag, " fill"}, 32'(fl), e.fill);
    chk({tag, " align_err"}, 32'(er), 32'(e.err));
    chk({tag, " reg0"}, a0, e.r0);
    chk({tag, " reg30"}, a30, e.r30);
  endtask

  task automatic cmp0(input string tag, input vec_t e);
    cmp(tag, e, win_valid0, fill0, err0, all0[0 +: W], all0[30*W +: W]);
  endtask

  task automatic beat0(input string tag, input vec_t v);
    vec_t e;
    in_valid0 = 1'b1;
    in_num0   = 2'(v.num);
    in_data0  = {v.d1, v.d0};
    sb0.push_back(v);
    #1 chk({tag, " in_ready"}, 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    e = sb0.pop_front();
    cmp0(tag, e);
  endtask

  task automatic beat1(input string tag, input vec_t v);
    vec_t e;
    in_valid1 = 1'b1;
    in_num1   = 1'(v.num);
    in_data1  = v.d0;
    sb1.push_back(v);
    #1 chk({tag, " in_ready"}, 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    e = sb1.pop_front();
    cmp(tag, e, win_valid1, fill1, err1, all1[0 +: W], all1[30*W +: W]);
  endtask

  task automatic clear_pulse();
    clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t zero_v;

    for (int k = 0; k < 15; k++)
      tbl[k] = '{num: 2, d0: 32'(2*k+1), d1: 32'(2*k+2), wv: 1'b0, fill: 2*k+2,
                 err: 1'b0, r0: 32'd0, r30: 32'(2*k+2)};
    tbl[15] = '{num: 1, d0: 32'd31, d1: 32'd0, wv: 1'b1, fill: 31,
                err: 1'b0, r0: 32'd1, r30: 32'd31};
    zero_v = '{num: 0, d0: 32'd0, d1: 32'd0, wv: 1'b0, fill: 0,
               err: 1'b0, r0: 32'd0, r30: 32'd0};

    // Reset state
    #8;
    cmp0("reset", zero_v);
    chk("reset all_outputs zero", (all0 == '0) ? 32'd1 : 32'd0, 32'd1);
    chk("reset in_ready", 32'(in_ready0), 32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // First window: 15 two-lane beats then a single-lane beat
    for (int i = 0; i < 16; i++) beat0("fill", tbl[i]);

    // Pending window stalls input and freezes contents
    in_valid0 = 1'b1;
    in_num0   = 2'd2;
    in_data0  = {32'd33, 32'd32};
    v = '{num: 2, d0: 32'd32, d1: 32'd33, wv: 1'b1, fill: 31, err: 1'b0, r0: 32'd1, r30: 32'd31};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall in_ready", 32'(in_ready0), 32'd0);
      cmp0("stall", v);
    end
    win_ready0 = 1'b1;
    v.r0 = 32'd3;
    v.r30 = 32'd33;
    sb0.push_back(v);
    #1 chk("passthru in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    v = sb0.pop_front();
    cmp0("passthru", v);

    // Zero-lane beats: the consume still retires the window, data untouched
    v = '{num: 0, d0: 32'd77, d1: 32'd78, wv: 1'b0, fill: 31, err: 1'b0, r0: 32'd3, r30: 32'd33};
    beat0("zero_consume", v);
    win_ready0 = 1'b0;
    beat0("zero_idle", v);

    // Overshoot: 30 samples then a two-lane beat
    clear_pulse();
    for (int i = 0; i < 15; i++) beat0("mis_fill", tbl[i]);
    v = '{num: 2, d0: 32'd31, d1: 32'd32, wv: 1'b1, fill: 31, err: 1'b1, r0: 32'd2, r30: 32'd32};
    beat0("misalign", v);

    // Clear with a pending window and an offered beat
    in_valid0 = 1'b1;
    in_num0   = 2'd2;
    in_data0  = {32'd99, 32'd98};
    clear0    = 1'b1;
    #1 chk("clear in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    clear0    = 1'b0;
    in_valid0 = 1'b0;
    cmp0("clear", zero_v);
    chk("clear all_outputs zero", (all0 == '0) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 16; i++) beat0("refill", tbl[i]);

    // Asynchronous reset between edges
    clear_pulse();
    for (int i = 0; i < 10; i++) beat0("pre_rst", tbl[i]);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    cmp0("async_rst", zero_v);
    chk("async_rst all_outputs zero", (all0 == '0) ? 32'd1 : 32'd0, 32'd1);
    #12 rst_n = 1'b1;
    #1;
    chk("post_rst in_ready", 32'(in_ready0), 32'd1);
    chk("post_rst fill", 32'(fill0), 32'd0);

    // in_num above LANES: clamped to LANES and flagged
    v = '{num: 3, d0: 32'd7, d1: 32'd8, wv: 1'b0, fill: 2, err: 1'b1, r0: 32'd0, r30: 32'd8};
    beat0("lane_ovf", v);
    chk("lane_ovf reg29", all0[29*W +: W], 32'd7);

    // Stride-1 build: a window every cycle once full
    win_ready1 = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      v = '{num: 1, d0: 32'(k), d1: 32'd0, wv: (k >= 31), fill: (k >= 31) ? 31 : k,
            err: 1'b0, r0: (k >= 31) ? 32'(k-30) : 32'd0, r30: 32'(k)};
      beat1("stride1", v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
